// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and default widths.
// FETCH_MISALIGN_TRAP_EN adds the TRAP state for misaligned redirect targets.
package fetch_pkg;
  localparam int          PC_WIDTH   = 32;
  localparam int          INST_WIDTH = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DROP, ST_HOLD, ST_TRAP} fetch_state_e;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DROP, ST_HOLD} fetch_state_e;
`endif
endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC select: redirect target vs sequential pc+4, plus target alignment check.
// FETCH_MISALIGN_TRAP_EN exposes the misaligned flag instead of forcing alignment.
module fetch_pc_next #(
  parameter int PC_WIDTH = fetch_pkg::PC_WIDTH
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] pc_plus_4,
  output logic [PC_WIDTH-1:0] pc_next
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                misaligned
`endif
);
  import fetch_pkg::*;

  always_comb begin
    // Wraps modulo 2^PC_WIDTH by construction.
    pc_plus_4 = pc + PC_WIDTH'(4);
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    pc_next    = redirect_valid ? redirect_pc : pc_plus_4;
`else
    pc_next    = redirect_valid ? (redirect_pc & ~PC_WIDTH'(3)) : pc_plus_4;
`endif
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, single output register.
// FETCH_MISALIGN_TRAP_EN adds fetch_misaligned and the TRAP state.
module fetch_ctrl #(
  parameter int                         PC_WIDTH   = fetch_pkg::PC_WIDTH,
  parameter int                         INST_WIDTH = fetch_pkg::INST_WIDTH,
  parameter logic [PC_WIDTH-1:0]        RESET_PC   = PC_WIDTH'(fetch_pkg::RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic [PC_WIDTH-1:0]   if_pc_plus_4
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                  fetch_misaligned
`endif
);
  import fetch_pkg::*;

  fetch_state_e        state;
  logic [PC_WIDTH-1:0] pc, pc_plus_4, pc_next;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  logic pend;

  fetch_pc_next #(.PC_WIDTH(PC_WIDTH)) u_pc_next (
    .pc(pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_plus_4(pc_plus_4), .pc_next(pc_next), .misaligned(misaligned)
  );
`else
  fetch_pc_next #(.PC_WIDTH(PC_WIDTH)) u_pc_next (
    .pc(pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_plus_4(pc_plus_4), .pc_next(pc_next)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      pc           <= RESET_PC;
      if_inst      <= '0;
      if_pc        <= '0;
      if_pc_plus_4 <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      pend         <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
      // A response may still be in flight when trapping; remember it so the exit drains it.
      pend <= (imem_req && imem_gnt) || (pend && !imem_rvalid);
      if (misaligned) begin
        state <= ST_TRAP;
        if_pc <= redirect_pc;
      end else
`endif
      case (state)
        ST_IDLE: begin
          if (redirect_valid) pc <= pc_next;
          state <= ST_REQ;
        end
        ST_REQ: begin
          if (redirect_valid) begin
            pc    <= pc_next;
            state <= imem_gnt ? ST_DROP : ST_REQ;
          end else if (imem_gnt) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            pc    <= pc_next;
            state <= imem_rvalid ? ST_REQ : ST_DROP;
          end else if (imem_rvalid) begin
            if_inst      <= imem_rdata;
            if_pc        <= pc;
            if_pc_plus_4 <= pc_plus_4;
            state        <= ST_HOLD;
          end
        end
        ST_DROP: begin
          if (redirect_valid) pc <= pc_next;
          if (imem_rvalid)    state <= ST_REQ;
        end
        ST_HOLD: begin
          // pc_next is the redirect target or pc+4, whichever applies.
          if (redirect_valid || if_ready) begin
            pc    <= pc_next;
            state <= ST_REQ;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        ST_TRAP: begin
          if (redirect_valid) begin
            pc    <= pc_next;
            state <= (pend && !imem_rvalid) ? ST_DROP : ST_REQ;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req  = (state == ST_REQ);
  assign imem_addr = pc;
  assign if_valid  = (state == ST_HOLD) && !redirect_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_misaligned = (state == ST_TRAP);
`endif
endmodule
